reg_dump_ctrl: RTL

REG_DUMP_CTRL -- requirements
Module: reg_dump_ctrl

---
 rtl/rvdbg_pkg.sv | 34 +++
 rtl/reg_dump_ctrl_if.sv | 13 +
 rtl/reg_dump_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/rvdbg_pkg.sv
// Shared definitions for the register-dump debug block.
// REG_DUMP_WRITE_EN adds the WRITE state used by the debug write path.
package rvdbg_pkg;

  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned XLEN     = 32;
  localparam int unsigned REG_AW   = 5;

  localparam logic [REG_AW-1:0] LAST_IDX = REG_AW'(NUM_REGS - 1);

`ifdef REG_DUMP_WRITE_EN
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_SEND  = 3'd2,
    ST_DONE  = 3'd3,
    ST_WRITE = 3'd4
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } state_e;
`endif

  // One dumped register: index plus the value read at that index.
  typedef struct packed {
    logic [REG_AW-1:0] idx;
    logic [XLEN-1:0]   data;
  } dump_word_t;

endpackage

// File: rtl/reg_dump_ctrl_if.sv
// Valid/ready stream carrying dumped register values and their indices.
interface reg_dump_ctrl_if;
  import rvdbg_pkg::*;

  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_data;
  logic [REG_AW-1:0] out_idx;

  modport master (output out_valid, output out_data, output out_idx, input out_ready);
  modport slave  (input out_valid, input out_data, input out_idx, output out_ready);

endinterface

// File: rtl/reg_dump_ctrl.sv
// Register-file dump controller: walks x0..x31 and streams each value out.
// Optional debug write port into the register file under REG_DUMP_WRITE_EN.
module reg_dump_ctrl
  import rvdbg_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  reg_dump_ctrl_if.master   out_if,
  output logic [REG_AW-1:0] rf_A,
  input  logic [XLEN-1:0]   rf_RD
`ifdef REG_DUMP_WRITE_EN
  ,
  output logic [REG_AW-1:0] rf_A3,
  output logic [XLEN-1:0]   rf_WD3,
  output logic              rf_WE3,
  input  logic              wr_req,
  input  logic [REG_AW-1:0] wr_addr,
  input  logic [XLEN-1:0]   wr_data,
  output logic              wr_ack
`endif
);

  state_e            state_q, state_d;
  logic [REG_AW-1:0] idx_q, idx_d;
  dump_word_t        word_q, word_d;
  logic              valid_q;
  logic              accept;

  logic              busy_d;
  logic              done_d;
  logic              valid_d;
  logic [REG_AW-1:0] rf_a_d;
`ifdef REG_DUMP_WRITE_EN
  logic              we_d;
  logic [REG_AW-1:0] a3_d;
  logic [XLEN-1:0]   wd3_d;
  logic              ack_d;
`endif

  assign accept           = valid_q & out_if.out_ready;
  assign out_if.out_valid = valid_q;
  assign out_if.out_data  = word_q.data;
  assign out_if.out_idx   = word_q.idx;

  // State and index registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state and index sequencing; a write request outranks start in IDLE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      ST_IDLE: begin
`ifdef REG_DUMP_WRITE_EN
        if (wr_req) begin
          state_d = ST_WRITE;
        end else if (start) begin
          state_d = ST_READ;
          idx_d   = '0;
        end
`else
        if (start) begin
          state_d = ST_READ;
          idx_d   = '0;
        end
`endif
      end
      ST_READ: state_d = ST_SEND;
      ST_SEND: begin
        if (accept) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_READ;
            idx_d   = idx_q + REG_AW'(1);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
`ifdef REG_DUMP_WRITE_EN
      ST_WRITE: state_d = ST_IDLE;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode from the upcoming state so every output is registered.
  always_comb begin
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
    valid_d = (state_d == ST_SEND);
    rf_a_d  = (state_d == ST_READ) ? idx_d : '0;
    word_d  = word_q;
    if (state_q == ST_READ) begin
      word_d.idx  = idx_q;
      word_d.data = rf_RD;
    end
`ifdef REG_DUMP_WRITE_EN
    we_d  = (state_d == ST_WRITE);
    a3_d  = we_d ? wr_addr : '0;
    wd3_d = we_d ? wr_data : '0;
    ack_d = we_d;
`endif
  end

  // Output registers, all cleared by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      valid_q <= 1'b0;
      rf_A    <= '0;
      word_q  <= '0;
`ifdef REG_DUMP_WRITE_EN
      rf_WE3  <= 1'b0;
      rf_A3   <= '0;
      rf_WD3  <= '0;
      wr_ack  <= 1'b0;
`endif
    end else begin
      busy    <= busy_d;
      done    <= done_d;
      valid_q <= valid_d;
      rf_A    <= rf_a_d;
      word_q  <= word_d;
`ifdef REG_DUMP_WRITE_EN
      rf_WE3  <= we_d;
      rf_A3   <= a3_d;
      rf_WD3  <= wd3_d;
      wr_ack  <= ack_d;
`endif
    end
  end

endmodule
